// File: rtl/sram1rw_gen_pkg.sv
// sram_gen_pkg: shared types and elaboration helpers for the sram1rw_gen family.
//   clr_state_e  - clear sequencer states
//   num_lanes    - write-mask lane count for a word width / lane granularity
//   addr_width   - address bits needed for a given depth (minimum 1)
//   latency_ok   - legal READ_LATENCY values (1 or 2)
//   mask_ok      - lane granularity must evenly divide the word width
package sram_gen_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    function automatic int num_lanes(input int word_width, input int mask_gran);
        return word_width / mask_gran;
    endfunction

    function automatic int addr_width(input int num_words);
        return (num_words > 1) ? $clog2(num_words) : 1;
    endfunction

    function automatic bit latency_ok(input int read_latency);
        return (read_latency == 1) || (read_latency == 2);
    endfunction

    function automatic bit mask_ok(input int word_width, input int mask_gran);
        return (mask_gran > 0) && ((word_width % mask_gran) == 0);
    endfunction

endpackage

// File: rtl/sram1rw_gen_if.sv
// sram1rw_gen_if: access bus of the 1RW SRAM model.
//   CSB  - chip select, active-low          (master -> slave)
//   WEB  - 0 = write, 1 = read              (master -> slave)
//   OEB  - output enable, active-low        (master -> slave)
//   A    - word address                     (master -> slave)
//   I    - write data                       (master -> slave)
//   BWEB - per-lane write enable, active-low(master -> slave)
//   O    - read data, tri-stated by OEB     (slave -> master)
//   BUSY - clear sequencer owns the array   (slave -> master)
interface sram1rw_gen_if
    import sram_gen_pkg::*;
#(
    parameter int WORD_WIDTH = 8,
    parameter int ADDR_WIDTH = addr_width(256),
    parameter int NUM_LANES  = num_lanes(8, 1)
);

    logic                  CSB;
    logic                  WEB;
    logic                  OEB;
    logic [ADDR_WIDTH-1:0] A;
    logic [WORD_WIDTH-1:0] I;
    logic [NUM_LANES-1:0]  BWEB;
    logic [WORD_WIDTH-1:0] O;
    logic                  BUSY;

    modport master (
        output CSB, WEB, OEB, A, I, BWEB,
        input  O, BUSY
    );

    modport slave (
        input  CSB, WEB, OEB, A, I, BWEB,
        output O, BUSY
    );

endinterface

// File: rtl/sram1rw_gen_clr.sv
// sram1rw_gen_clr: post-reset clear sequencer. Sweeps every word to zero,
// one word per cycle, and owns the array (busy_o) while it does so.
//   clk_i      - clock
//   rst_ni     - synchronous active-low reset; restarts the sweep at word 0
//   clr_we_o   - array write strobe for the clear sweep
//   clr_addr_o - word being cleared
//   busy_o     - high while the sweep is running (registered state decode)
//
// state | meaning
// IDLE  | array belongs to the access port; stays here until the next reset
// CLEAR | writing zero to word ptr_q, one word per cycle
module sram1rw_gen_clr
    import sram_gen_pkg::*;
#(
    parameter int NUM_WORDS      = 256,
    parameter int ADDR_WIDTH     = addr_width(NUM_WORDS),
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    output logic                  clr_we_o,
    output logic [ADDR_WIDTH-1:0] clr_addr_o,
    output logic                  busy_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(NUM_WORDS - 1);

    clr_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= CLEAR_ON_RESET ? CLEAR : IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        clr_we_o = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we_o = 1'b1;
                if (ptr_q == LAST_WORD) begin
                    state_d = IDLE;
                end else begin
                    ptr_d = ptr_q + ADDR_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign clr_addr_o = ptr_q;
    assign busy_o     = (state_q == CLEAR);

endmodule

// File: rtl/sram1rw_gen.sv
// sram1rw_gen: parametrised single-port synchronous SRAM model with per-lane
// active-low write mask, 1- or 2-cycle read latency and optional zeroing of
// the array after reset.
//   CE   - clock, all state updates on the rising edge
//   RSTB - synchronous active-low reset (read stages and clear sequencer only;
//          array contents are never touched by reset itself)
//   bus  - slave side of sram1rw_gen_if (CSB/WEB/OEB/A/I/BWEB in, O/BUSY out)
module sram1rw_gen
    import sram_gen_pkg::*;
#(
    parameter int WORD_WIDTH     = 8,
    parameter int NUM_WORDS      = 256,
    parameter int ADDR_WIDTH     = addr_width(NUM_WORDS),
    parameter int MASK_GRAN      = 1,
    parameter int READ_LATENCY   = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic         CE,
    input  logic         RSTB,
    sram1rw_gen_if.slave bus
);

    localparam int NUM_LANES = num_lanes(WORD_WIDTH, MASK_GRAN);
    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(NUM_WORDS);

    if (!latency_ok(READ_LATENCY)) begin : g_bad_latency
        $error("sram1rw_gen: READ_LATENCY must be 1 or 2");
    end
    if (!mask_ok(WORD_WIDTH, MASK_GRAN)) begin : g_bad_mask
        $error("sram1rw_gen: MASK_GRAN must divide WORD_WIDTH");
    end

    logic [WORD_WIDTH-1:0] mem_q [NUM_WORDS];
    logic [WORD_WIDTH-1:0] stage1_q;
    logic [WORD_WIDTH-1:0] rd_data;
    logic [WORD_WIDTH-1:0] wr_mask;
    logic [WORD_WIDTH-1:0] wr_data;
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  busy;
    logic                  in_range;
    logic                  acc;
    logic                  re;
    logic                  we;

    sram1rw_gen_clr #(
        .NUM_WORDS      (NUM_WORDS),
        .ADDR_WIDTH     (ADDR_WIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clr (
        .clk_i      (CE),
        .rst_ni     (RSTB),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr),
        .busy_o     (busy)
    );

    // Requests seen while the sweep runs are dropped, not deferred.
    assign in_range = ({1'b0, bus.A} < DEPTH);
    assign acc      = ~bus.CSB & ~busy;
    assign re       = acc & bus.WEB;
    assign we       = acc & ~bus.WEB & in_range;

    for (genvar b = 0; b < WORD_WIDTH; b++) begin : g_mask
        assign wr_mask[b] = ~bus.BWEB[b / MASK_GRAN];
    end

    assign wr_data = (mem_q[bus.A] & ~wr_mask) | (bus.I & wr_mask);

    // The clear sweep and the access port are mutually exclusive through
    // busy, so the priority here only matters for the reset edge itself.
    always_ff @(posedge CE) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else if (we) begin
            mem_q[bus.A] <= wr_data;
        end
    end

    // stage1 only moves on a read; writes never disturb the held read data.
    always_ff @(posedge CE) begin
        if (!RSTB) begin
            stage1_q <= '0;
        end else if (re) begin
            stage1_q <= in_range ? mem_q[bus.A] : '0;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [WORD_WIDTH-1:0] stage2_q;

        always_ff @(posedge CE) begin
            if (!RSTB) begin
                stage2_q <= '0;
            end else begin
                stage2_q <= stage1_q;
            end
        end

        assign rd_data = stage2_q;
    end else begin : g_lat1
        assign rd_data = stage1_q;
    end

    assign bus.O    = bus.OEB ? {WORD_WIDTH{1'bz}} : rd_data;
    assign bus.BUSY = busy;

endmodule

// File: tb/tb_sram1rw_gen.sv
module tb_sram1rw_gen;

    logic ce    = 1'b0;
    logic rstb0 = 1'b0;
    logic rstb1 = 1'b0;

    always #5 ce = ~ce;

    // u0: defaults (8b x 256, bit mask, latency 1, clear on reset)
    // u1: 32b x 100, byte mask, latency 2, clear on reset
    sram1rw_gen_if #(.WORD_WIDTH(8),  .ADDR_WIDTH(8), .NUM_LANES(8)) bus0 ();
    sram1rw_gen_if #(.WORD_WIDTH(32), .ADDR_WIDTH(7), .NUM_LANES(4)) bus1 ();

    sram1rw_gen u0 (
        .CE   (ce),
        .RSTB (rstb0),
        .bus  (bus0)
    );

    sram1rw_gen #(
        .WORD_WIDTH     (32),
        .NUM_WORDS      (100),
        .MASK_GRAN      (8),
        .READ_LATENCY   (2),
        .CLEAR_ON_RESET (1'b1)
    ) u1 (
        .CE   (ce),
        .RSTB (rstb1),
        .bus  (bus1)
    );

    typedef struct {
        int          due;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock edge, then retire every scoreboard entry due at this cycle.
    task automatic tick();
        exp_t e;
        @(posedge ce);
        #1;
        cyc++;
        while (q0.size() > 0 && q0[0].due <= cyc) begin
            e = q0.pop_front();
            check(e.tag, 32'(bus0.O), e.exp);
        end
        while (q1.size() > 0 && q1[0].due <= cyc) begin
            e = q1.pop_front();
            check(e.tag, bus1.O, e.exp);
        end
    endtask

    task automatic wr0(input logic [7:0] a, input logic [7:0] d, input logic [7:0] bweb);
        bus0.CSB = 1'b0; bus0.WEB = 1'b0; bus0.A = a; bus0.I = d; bus0.BWEB = bweb;
        tick();
        bus0.CSB = 1'b1;
    endtask

    task automatic rd0(input logic [7:0] a, input logic [7:0] exp, input string tag);
        bus0.CSB = 1'b0; bus0.WEB = 1'b1; bus0.A = a;
        q0.push_back('{due: cyc + 1, exp: 32'(exp), tag: tag});
        tick();
        bus0.CSB = 1'b1;
    endtask

    task automatic wr1(input logic [6:0] a, input logic [31:0] d, input logic [3:0] bweb);
        bus1.CSB = 1'b0; bus1.WEB = 1'b0; bus1.A = a; bus1.I = d; bus1.BWEB = bweb;
        tick();
        bus1.CSB = 1'b1;
    endtask

    task automatic rd1(input logic [6:0] a, input logic [31:0] exp, input string tag);
        bus1.CSB = 1'b0; bus1.WEB = 1'b1; bus1.A = a;
        q1.push_back('{due: cyc + 2, exp: exp, tag: tag});
        tick();
        bus1.CSB = 1'b1;
    endtask

    initial begin
        int   fall0;
        int   fall1;
        logic tri_ok;

        bus0.CSB = 1'b1; bus0.WEB = 1'b1; bus0.OEB = 1'b0;
        bus0.A = '0; bus0.I = '0; bus0.BWEB = '1;
        bus1.CSB = 1'b1; bus1.WEB = 1'b1; bus1.OEB = 1'b0;
        bus1.A = '0; bus1.I = '0; bus1.BWEB = '1;

        // Reset state
        tick();
        tick();
        check("rst_busy0", 32'(bus0.BUSY), 32'd1);
        check("rst_busy1", 32'(bus1.BUSY), 32'd1);
        check("rst_o0",    32'(bus0.O),    32'h0);
        check("rst_o1",    bus1.O,         32'h0);

        // Clear sweep length; a write to A=3 lands after the sweep passed it
        rstb0 = 1'b1;
        rstb1 = 1'b1;
        fall0 = 0;
        fall1 = 0;
        for (int i = 1; i <= 400 && (fall0 == 0 || fall1 == 0); i++) begin
            if (i == 10) begin
                bus0.CSB = 1'b0; bus0.WEB = 1'b0; bus0.A = 8'd3; bus0.I = 8'h77; bus0.BWEB = '0;
            end
            tick();
            bus0.CSB = 1'b1;
            if (fall0 == 0 && bus0.BUSY == 1'b0) fall0 = i;
            if (fall1 == 0 && bus1.BUSY == 1'b0) fall1 = i;
        end
        check("clear_len0", 32'(fall0), 32'd256);
        check("clear_len1", 32'(fall1), 32'd100);

        // Cleared contents, including the write discarded while busy
        rd0(8'h00, 8'h00, "clr_rd_00");
        rd0(8'h7F, 8'h00, "clr_rd_7f");
        rd0(8'hFF, 8'h00, "clr_rd_ff");
        rd0(8'h03, 8'h00, "busy_wr_dropped");
        rd1(7'd0,  32'h0, "clr1_rd_0");
        rd1(7'd99, 32'h0, "clr1_rd_99");

        // Back-to-back pipelined reads, latency 1
        wr0(8'd1, 8'h10, 8'h00);
        wr0(8'd2, 8'h20, 8'h00);
        wr0(8'd3, 8'h30, 8'h00);
        rd0(8'd1, 8'h10, "lat1_rd1");
        rd0(8'd2, 8'h20, "lat1_rd2");
        rd0(8'd3, 8'h30, "lat1_rd3");

        // Back-to-back pipelined reads, latency 2
        wr1(7'd1, 32'h10, 4'h0);
        wr1(7'd2, 32'h20, 4'h0);
        wr1(7'd3, 32'h30, 4'h0);
        rd1(7'd1, 32'h10, "lat2_rd1");
        rd1(7'd2, 32'h20, "lat2_rd2");
        rd1(7'd3, 32'h30, "lat2_rd3");
        tick();

        // Byte-lane mask
        wr1(7'd5, 32'hAABBCCDD, 4'b0000);
        wr1(7'd5, 32'h11223344, 4'b1010);
        rd1(7'd5, 32'hAA22CC44, "byte_mask");

        // Out of range write dropped / read returns zero; last word usable
        wr1(7'd120, 32'h5A, 4'h0);
        rd1(7'd120, 32'h0, "oor_rd");
        wr1(7'd99, 32'h3C, 4'h0);
        rd1(7'd99, 32'h3C, "last_word");
        tick();

        // Bit-lane mask and all-ones mask no-op
        wr0(8'd9, 8'hFF, 8'h00);
        wr0(8'd9, 8'h00, 8'hF0);
        wr0(8'd9, 8'h12, 8'hFF);
        rd0(8'd9, 8'hF0, "bit_mask");

        // OEB: tri-state during read, held data afterwards, write leaves O alone
        bus0.OEB = 1'b1;
        bus0.CSB = 1'b0; bus0.WEB = 1'b1; bus0.A = 8'd2;
        tick();
        bus0.CSB = 1'b1;
        tri_ok = (bus0.O === 8'hzz) || (bus0.O === 8'h00);
        n_vec++;
        assert (tri_ok)
        else begin
            n_err++;
            $error("FAIL oeb_tristate: observed %h expected zz", bus0.O);
        end
        bus0.OEB = 1'b0;
        tick();
        check("oeb_held", 32'(bus0.O), 32'h20);
        wr0(8'd2, 8'h55, 8'h00);
        check("wr_keeps_o", 32'(bus0.O), 32'h20);
        rd0(8'd2, 8'h55, "rd_after_wr");

        // Reset mid-pipeline, then reset mid-clear at ptr=40
        bus0.CSB = 1'b0; bus0.WEB = 1'b1; bus0.A = 8'd2;
        rstb0 = 1'b0;
        tick();
        bus0.CSB = 1'b1;
        check("rst_pipe_o", 32'(bus0.O), 32'h0);
        check("rst_busy_again", 32'(bus0.BUSY), 32'd1);
        rstb0 = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        check("mid_clear_busy", 32'(bus0.BUSY), 32'd1);
        rstb0 = 1'b0;
        tick();
        rstb0 = 1'b1;
        fall0 = 0;
        for (int i = 1; i <= 400 && fall0 == 0; i++) begin
            tick();
            if (bus0.BUSY == 1'b0) fall0 = i;
        end
        check("restart_len", 32'(fall0), 32'd256);
        rd0(8'd2, 8'h00, "recleared_2");
        rd0(8'd9, 8'h00, "recleared_9");

        tick();
        tick();
        tick();
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sram1rw_gen.md
# sram1rw_gen

Parametrised single-port synchronous SRAM behavioural model, the next generation of the fixed-size 1RW macros in the data-extension SRAM set. Adds configurable word width and depth, per-lane active-low write mask, selectable 1- or 2-cycle read latency, and a hardware clear sequencer that zeroes the array after reset. Drop-in for the fixed 1RW macros wherever a non-standard geometry or deterministic power-up contents are required.

## Interface
- WORD_WIDTH, 8: data bits per word.
- NUM_WORDS, 256: words in the array; need not be a power of two.
- ADDR_WIDTH, $clog2(NUM_WORDS): address bits.
- MASK_GRAN, 1: bits per write-mask lane; WORD_WIDTH % MASK_GRAN == 0; NUM_LANES = WORD_WIDTH/MASK_GRAN.
- READ_LATENCY, 1: 1 or 2; any other value is an elaboration error.
- CLEAR_ON_RESET, 1: 1 = zero the whole array after reset; 0 = array contents untouched by reset.
- CE  in  1  clock; all state updates on rising edge.
- RSTB  in  1  reset, synchronous, active-low.
- CSB  in  1  chip select, active-low.
- WEB  in  1  0 = write, 1 = read (when selected).
- OEB  in  1  output enable, active-low; 1 tri-states O.
- A  in  ADDR_WIDTH  word address.
- I  in  WORD_WIDTH  write data.
- BWEB  in  NUM_LANES  per-lane write enable, active-low.
- O  out  WORD_WIDTH  read data (combinationally tri-stated by OEB).
- BUSY  out  1  1 while the clear sequencer owns the array.

## Operation
- Access qualifier: acc = ~CSB & ~BUSY. RE = acc & WEB; WE = acc & ~WEB.
- Write: for each lane k with BWEB[k]=0, mem[A] lane k <= I lane k. Lanes with BWEB[k]=1 keep old value. All-ones BWEB = no-op.
- Read: stage1 <= mem[A]. stage1 holds its value on cycles without RE (including writes); a write never alters stage1, even to the same address.
- READ_LATENCY=2: stage2 <= stage1 every cycle; O sources stage2. READ_LATENCY=1: O sources stage1.
- O = OEB ? 'z : selected stage. OEB does not affect internal state.
- Out of range (A >= NUM_WORDS): write dropped; read loads stage1 with 0.
- Clear FSM states: IDLE, CLEAR.
  - Reset (RSTB=0 at edge): stage1, stage2 <= 0; ptr <= 0; state <= CLEAR if CLEAR_ON_RESET else IDLE.
  - CLEAR: mem[ptr] <= 0, ptr <= ptr+1; at ptr == NUM_WORDS-1 write last word and go IDLE.
  - IDLE: stays IDLE until next reset.
- BUSY = (state == CLEAR), registered. Requests presented while BUSY=1 are discarded, not queued.
- Reset mid-clear restarts the sweep at address 0. Reset mid-read pipeline: both stages forced to 0.

## Timing
- Reset values: stage1 = 0, stage2 = 0, O = 0 when OEB=0, BUSY = CLEAR_ON_RESET (from first edge with RSTB=0).
- Clear duration: exactly NUM_WORDS cycles after the first edge with RSTB=1; BUSY falls on edge NUM_WORDS; first accepted access on that same edge's following cycle.
- Read latency: request sampled at edge n; O valid after edge n (LAT 1) or edge n+1 (LAT 2).
- Write visible to a read sampled at edge n+1 or later.
- Back-to-back reads fully pipelined, one per cycle, both latencies.

## Structure
- Package sram_gen_pkg: clear-state enum (IDLE, CLEAR), lane-count/address-width helper functions, READ_LATENCY legality check.
- Sub-module sram1rw_gen_clr: clear FSM, ptr counter, BUSY; outputs clear write-enable and address to the array.
- Array, mask merge, read stages and tri-state in sram1rw_gen top.

## Test plan
- Defaults, CLEAR_ON_RESET=1: release RSTB -> BUSY=1 for 256 cycles, then 0; reads of 0x00, 0x7F, 0xFF return 0x00.
- WORD_WIDTH=32, MASK_GRAN=8: write 0xAABBCCDD to A=5, then I=0x11223344 BWEB=4'b1010 -> read A=5 returns 0xAA22CC44.
- READ_LATENCY=2: reads A=1,2,3 on consecutive edges holding 0x10,0x20,0x30 -> O = 0x10,0x20,0x30 after edges n+1, n+2, n+3; LAT=1 same sequence one cycle earlier.
- NUM_WORDS=100: write 0x5A to A=120 then read A=120 -> O=0x00; read A=99 after write 0x3C -> 0x3C.
- Write 0x77 to A=3 issued while BUSY=1 -> after clear, read A=3 returns 0x00; RSTB low at ptr=40 -> sweep restarts, BUSY high a further 256 cycles.
- OEB=1 during read -> O='z; OEB=0 next cycle without new read -> O shows held read data; write to same address does not change O.
